// File: rtl/adder_pkg.sv
// Shared definitions for the adder datapath and its downstream accumulator.
package adder_pkg;

  // Width of the registered 2-bit adder's sum output (0..7).
  localparam int unsigned SUM_W = 3;

  // Accumulator control states: collecting samples, or holding a finished group.
  typedef enum logic [0:0] {
    ACC,
    DONE
  } acc_state_t;

endpackage

// File: rtl/sat_add.sv
// Combinational unsigned saturating adder: a + b clamped to all-ones of width A_W.
module sat_add #(
  parameter int unsigned A_W = 8,
  parameter int unsigned B_W = 3
) (
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic [A_W-1:0] sum,
  output logic           sat
);

  logic [A_W:0] full;

  // One extra bit catches the carry; it is the saturate indication.
  always_comb begin
    full = {1'b0, a} + {{(A_W + 1 - B_W){1'b0}}, b};
    sat  = full[A_W];
    sum  = sat ? {A_W{1'b1}} : full[A_W-1:0];
  end

endmodule

// File: rtl/sum_accumulator.sv
// Groups COUNT adder sums into a saturating total, delivered on a valid/ready port.
module sum_accumulator
  import adder_pkg::*;
#(
  parameter int unsigned COUNT = 4,
  parameter int unsigned OUT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] s_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] total,
  output logic             overflow
);

  localparam int unsigned CNT_W = $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT);

  acc_state_t       state_q, state_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flag_q, flag_d;
  logic [OUT_W-1:0] total_q, total_d;
  logic             overflow_q, overflow_d;

  logic             accept;
  logic             last;
  logic [CNT_W-1:0] cnt_inc;
  logic [OUT_W-1:0] sum;
  logic             sat;

  assign in_ready  = (state_q == ACC) | ((state_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign cnt_inc   = cnt_q + 1'b1;
  assign last      = (cnt_inc == CNT_LAST);
  assign out_valid = (state_q == DONE);
  assign total     = total_q;
  assign overflow  = overflow_q;

  sat_add #(
    .A_W(OUT_W),
    .B_W(SUM_W)
  ) u_sat_add (
    .a  (acc_q),
    .b  (s_in),
    .sum(sum),
    .sat(sat)
  );

  // Next-state: accumulate accepted samples, complete a group, release on handshake.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    flag_d     = flag_q;
    total_d    = total_q;
    overflow_d = overflow_q;

    if ((state_q == DONE) && out_ready) begin
      state_d = ACC;
    end

    // acc/cnt are already zero while in DONE, so a sample accepted on the
    // handshake cycle naturally starts the next group.
    if (clear) begin
      acc_d  = '0;
      cnt_d  = '0;
      flag_d = 1'b0;
    end else if (accept) begin
      if (last) begin
        total_d    = sum;
        overflow_d = flag_q | sat;
        state_d    = DONE;
        acc_d      = '0;
        cnt_d      = '0;
        flag_d     = 1'b0;
      end else begin
        acc_d  = sum;
        cnt_d  = cnt_inc;
        flag_d = flag_q | sat;
      end
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ACC;
      acc_q      <= '0;
      cnt_q      <= '0;
      flag_q     <= 1'b0;
      total_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      flag_q     <= flag_d;
      total_q    <= total_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Scoreboard bench for sum_accumulator: one 8-bit and one 4-bit instance share stimulus.
module tb_sum_accumulator;

  logic       clk;
  logic       reset;
  logic       clear;
  logic       in_valid;
  logic [2:0] s_in;
  logic       out_ready;

  logic       in_ready8, out_valid8, overflow8;
  logic [7:0] total8;
  logic       in_ready4, out_valid4, overflow4;
  logic [3:0] total4;

  sum_accumulator #(
    .COUNT(4),
    .OUT_W(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready8),
    .s_in     (s_in),
    .out_valid(out_valid8),
    .out_ready(out_ready),
    .total    (total8),
    .overflow (overflow8)
  );

  sum_accumulator #(
    .COUNT(4),
    .OUT_W(4)
  ) dut_sat (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready4),
    .s_in     (s_in),
    .out_valid(out_valid4),
    .out_ready(out_ready),
    .total    (total4),
    .overflow (overflow4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] t8;
    logic       o8;
    logic [3:0] t4;
    logic       o4;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Reference model state.
  logic m_done;
  int   m_cnt;
  int   m_acc8, m_acc4;
  logic m_f8, m_f4;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_cnt  = 0;
    m_acc8 = 0;
    m_acc4 = 0;
    m_f8   = 1'b0;
    m_f4   = 1'b0;
  endtask

  // Called at a negedge: apply inputs, check outputs, advance the model to the next edge.
  task automatic drive(input logic v, input logic [2:0] s, input logic rdy, input logic clr);
    logic m_ready;
    logic m_done_n;
    exp_t e;
    in_valid  = v;
    s_in      = s;
    out_ready = rdy;
    clear     = clr;
    #1;
    m_ready = !m_done || rdy;
    check("in_ready8", in_ready8, m_ready);
    check("in_ready4", in_ready4, m_ready);
    check("out_valid8", out_valid8, m_done);
    check("out_valid4", out_valid4, m_done);
    if (m_done) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        e = sb[0];
        check("total8", total8, e.t8);
        check("overflow8", overflow8, e.o8);
        check("total4", total4, e.t4);
        check("overflow4", overflow4, e.o4);
        if (rdy) void'(sb.pop_front());
      end
    end
    m_done_n = m_done && !rdy;
    if (clr) begin
      model_clear();
    end else if (v && m_ready) begin
      m_acc8 = m_acc8 + s;
      if (m_acc8 > 255) begin
        m_acc8 = 255;
        m_f8   = 1'b1;
      end
      m_acc4 = m_acc4 + s;
      if (m_acc4 > 15) begin
        m_acc4 = 15;
        m_f4   = 1'b1;
      end
      m_cnt++;
      if (m_cnt == 4) begin
        e.t8 = m_acc8[7:0];
        e.o8 = m_f8;
        e.t4 = m_acc4[3:0];
        e.o4 = m_f4;
        sb.push_back(e);
        m_done_n = 1'b1;
        model_clear();
      end
    end
    m_done = m_done_n;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 3'd0, 1'b1, 1'b0);
  endtask

  // Pulse reset between edges and confirm the outputs clear immediately.
  task automatic reset_pulse();
    in_valid = 1'b0;
    clear    = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_out_valid8", out_valid8, 0);
    check("rst_total8", total8, 0);
    check("rst_overflow8", overflow8, 0);
    check("rst_out_valid4", out_valid4, 0);
    check("rst_total4", total4, 0);
    check("rst_overflow4", overflow4, 0);
    #1 reset = 1'b0;
    m_done = 1'b0;
    model_clear();
    sb.delete();
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    s_in      = 3'd0;
    out_ready = 1'b1;
    m_done    = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    check("reset_in_ready8", in_ready8, 1);
    check("reset_out_valid8", out_valid8, 0);
    check("reset_total8", total8, 0);
    check("reset_overflow8", overflow8, 0);
    check("reset_total4", total4, 0);
    reset = 1'b0;
    @(negedge clk);

    // Basic group: 2+1+3+5 = 11.
    drive(1'b1, 3'd2, 1'b1, 1'b0);
    drive(1'b1, 3'd1, 1'b1, 1'b0);
    drive(1'b1, 3'd3, 1'b1, 1'b0);
    drive(1'b1, 3'd5, 1'b1, 1'b0);
    idle(3);

    // Saturation on the 4-bit instance, then a clean group clears the flag.
    for (int i = 0; i < 4; i++) drive(1'b1, 3'd7, 1'b1, 1'b0);
    idle(2);
    for (int i = 0; i < 4; i++) drive(1'b1, 3'd1, 1'b1, 1'b0);
    idle(2);

    // Backpressure: sum 6 held for 3 cycles while 7s are offered and refused.
    drive(1'b1, 3'd1, 1'b1, 1'b0);
    drive(1'b1, 3'd2, 1'b1, 1'b0);
    drive(1'b1, 3'd2, 1'b1, 1'b0);
    drive(1'b1, 3'd1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 3'd7, 1'b0, 1'b0);
    idle(2);

    // Back-to-back groups 1..4 and 5..8 with no bubble.
    for (int i = 1; i <= 8; i++) drive(1'b1, 3'(i % 8 == 0 ? 0 : i), 1'b1, 1'b0);
    idle(2);
    // Same with the full 1..8 pattern wrapping 8 to value 0 removed: use 3'd7 endpoint.
    for (int i = 1; i <= 7; i++) drive(1'b1, 3'(i), 1'b1, 1'b0);
    drive(1'b1, 3'd1, 1'b1, 1'b0);
    idle(2);

    // Clear drops the in-flight group and the sample offered with it.
    drive(1'b1, 3'd4, 1'b1, 1'b0);
    drive(1'b1, 3'd4, 1'b1, 1'b0);
    drive(1'b1, 3'd7, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 3'd1, 1'b1, 1'b0);
    idle(2);

    // Clear coincident with the 4th accept wins; then a held result survives clear.
    for (int i = 0; i < 3; i++) drive(1'b1, 3'd1, 1'b1, 1'b0);
    drive(1'b1, 3'd1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 3'd2, 1'b1, 1'b0);
    drive(1'b0, 3'd0, 1'b0, 1'b1);
    drive(1'b0, 3'd0, 1'b0, 1'b0);
    idle(2);

    // Reset mid-group discards the partial sum.
    drive(1'b1, 3'd3, 1'b1, 1'b0);
    drive(1'b1, 3'd3, 1'b1, 1'b0);
    reset_pulse();
    for (int i = 0; i < 4; i++) drive(1'b1, 3'd2, 1'b1, 1'b0);
    idle(2);

    // Reset while holding a result: no delivery.
    for (int i = 0; i < 4; i++) drive(1'b1, 3'd6, 1'b1, 1'b0);
    drive(1'b0, 3'd0, 1'b0, 1'b0);
    reset_pulse();
    idle(2);

    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
